// File: rtl/spu_pkg.sv
// Shared definitions for the SPU issue path.
//   - Execution unit IDs and their ID width.
//   - Architected register address width.
//   - Scheduler FSM state type.
//   - unit_latency(): cycles from issue until the result is forwardable.
package spu_pkg;

  localparam int UNIT_ID_SIZE   = 3;
  localparam int REG_ADDR_WIDTH = 7;
  localparam int LAT_WIDTH      = 4;

  localparam logic [UNIT_ID_SIZE-1:0] UNIT_FX1    = 3'd0;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_BYTE   = 3'd1;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_FX2    = 3'd2;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_PERM   = 3'd3;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_BRANCH = 3'd4;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_SP_FP  = 3'd5;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_LS     = 3'd6;
  localparam logic [UNIT_ID_SIZE-1:0] UNIT_SP_INT = 3'd7;

  // PAIR: both slots still pending. ODD_ONLY: even already issued, odd waits.
  typedef enum logic [0:0] {
    ST_PAIR     = 1'b0,
    ST_ODD_ONLY = 1'b1
  } sched_state_e;

  function automatic logic [LAT_WIDTH-1:0] unit_latency(input logic [UNIT_ID_SIZE-1:0] unit_id);
    logic [LAT_WIDTH-1:0] lat;
    case (unit_id)
      UNIT_FX1:    lat = 4'd2;
      UNIT_BYTE:   lat = 4'd3;
      UNIT_FX2:    lat = 4'd3;
      UNIT_PERM:   lat = 4'd3;
      UNIT_BRANCH: lat = 4'd3;
      UNIT_SP_FP:  lat = 4'd6;
      UNIT_LS:     lat = 4'd6;
      default:     lat = 4'd7; // UNIT_SP_INT
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard.
//   clk, reset           : clock, synchronous active-high reset (clears all counters)
//   ld0_* / ld1_*        : two load ports (even / odd issue), write cnt into c[addr]
//   even/odd_src_addr    : ra,rb,rc (ra in MSBs) of each slot
//   even/odd_src_rdy     : per-source ready (c == 0), bit 2 = ra
//   even/odd_rt_addr     : destination of each slot
//   even/odd_rt_cnt      : current counter of that destination (for the WAW check)
// A register is ready when its counter is zero. Nonzero counters count down one
// per cycle; a load on the same register overrides the decrement.
module reg_scoreboard #(
  parameter int NUM_REGS       = 128,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int CNT_WIDTH      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld0_en,
  input  logic [REG_ADDR_WIDTH-1:0]   ld0_addr,
  input  logic [CNT_WIDTH-1:0]        ld0_cnt,
  input  logic                        ld1_en,
  input  logic [REG_ADDR_WIDTH-1:0]   ld1_addr,
  input  logic [CNT_WIDTH-1:0]        ld1_cnt,
  input  logic [3*REG_ADDR_WIDTH-1:0] even_src_addr,
  input  logic [3*REG_ADDR_WIDTH-1:0] odd_src_addr,
  output logic [2:0]                  even_src_rdy,
  output logic [2:0]                  odd_src_rdy,
  input  logic [REG_ADDR_WIDTH-1:0]   even_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0]   odd_rt_addr,
  output logic [CNT_WIDTH-1:0]        even_rt_cnt,
  output logic [CNT_WIDTH-1:0]        odd_rt_cnt
);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      // The two ports never target the same register in one cycle; ld0 is
      // checked first only to keep the priority explicit.
      if (ld0_en && (ld0_addr == REG_ADDR_WIDTH'(r))) begin
        cnt_d[r] = ld0_cnt;
      end else if (ld1_en && (ld1_addr == REG_ADDR_WIDTH'(r))) begin
        cnt_d[r] = ld1_cnt;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      even_src_rdy[i] = (cnt_q[even_src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] == '0);
      odd_src_rdy[i]  = (cnt_q[odd_src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] == '0);
    end
    even_rt_cnt = cnt_q[even_rt_addr];
    odd_rt_cnt  = cnt_q[odd_rt_addr];
  end

endmodule

// File: rtl/issue_hazard_scheduler.sv
// Dual-issue scheduler between decode and register fetch (even/odd SPU pipes).
//   clk, reset              : clock, synchronous active-high reset
//   even_*/odd_* inputs     : decoded pair (valid, sources, source enables, rt, unit)
//   flush                   : drop the held pair; scoreboard keeps counting
//   issue_even / issue_odd  : slot enters register fetch this cycle (combinational)
//   pair_ready              : decode may present the next pair next cycle (combinational)
//   stall_count             : saturating count of stall cycles
//   dbg_state               : current FSM state (0 = PAIR, 1 = ODD_ONLY)
// Handshake: decode holds the pair stable until it sees pair_ready high in a
// cycle; issue_* pulses mark the cycle each slot is accepted, and a slot is
// accepted exactly once per pair.
module issue_hazard_scheduler
  import spu_pkg::*;
#(
  parameter int NUM_REGS        = 128,
  parameter int REG_ADDR_WIDTH  = 7,
  parameter int CNT_WIDTH       = 3,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        even_valid,
  input  logic [3*REG_ADDR_WIDTH-1:0] even_src_addr,
  input  logic [2:0]                  even_src_used,
  input  logic                        even_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]   even_rt_addr,
  input  logic [UNIT_ID_SIZE-1:0]     even_unit,
  input  logic                        odd_valid,
  input  logic [3*REG_ADDR_WIDTH-1:0] odd_src_addr,
  input  logic [2:0]                  odd_src_used,
  input  logic                        odd_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]   odd_rt_addr,
  input  logic [UNIT_ID_SIZE-1:0]     odd_unit,
  input  logic                        flush,
  output logic                        issue_even,
  output logic                        issue_odd,
  output logic                        pair_ready,
  output logic [STALL_CNT_WIDTH-1:0]  stall_count,
  output logic                        dbg_state
);

  sched_state_e               state_q, state_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic [2:0]           even_src_rdy, odd_src_rdy;
  logic [CNT_WIDTH-1:0] even_rt_cnt, odd_rt_cnt;
  logic                 even_go, odd_go, pair_rdy;
  logic                 even_srcs_ok, odd_srcs_ok, even_waw_ok, odd_waw_ok;
  logic                 odd_reads_even_rt, intra_block, odd_order_ok, even_done;

  reg_scoreboard #(
    .NUM_REGS       (NUM_REGS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_sb (
    .clk           (clk),
    .reset         (reset),
    .ld0_en        (even_go && even_wr_en),
    .ld0_addr      (even_rt_addr),
    .ld0_cnt       (CNT_WIDTH'(unit_latency(even_unit) - LAT_WIDTH'(1))),
    .ld1_en        (odd_go && odd_wr_en),
    .ld1_addr      (odd_rt_addr),
    .ld1_cnt       (CNT_WIDTH'(unit_latency(odd_unit) - LAT_WIDTH'(1))),
    .even_src_addr (even_src_addr),
    .odd_src_addr  (odd_src_addr),
    .even_src_rdy  (even_src_rdy),
    .odd_src_rdy   (odd_src_rdy),
    .even_rt_addr  (even_rt_addr),
    .odd_rt_addr   (odd_rt_addr),
    .even_rt_cnt   (even_rt_cnt),
    .odd_rt_cnt    (odd_rt_cnt)
  );

  always_comb begin
    even_done    = (state_q == ST_ODD_ONLY);
    even_srcs_ok = &(even_src_rdy | ~even_src_used);
    odd_srcs_ok  = &(odd_src_rdy | ~odd_src_used);
    // WAW: the younger write must land strictly after the older one still in flight.
    even_waw_ok  = !even_wr_en ||
                   ((int'(even_rt_cnt) + 2) <= int'(unit_latency(even_unit)));
    odd_waw_ok   = !odd_wr_en ||
                   ((int'(odd_rt_cnt) + 2) <= int'(unit_latency(odd_unit)));

    even_go = !reset && !flush && even_valid && !even_done && even_srcs_ok && even_waw_ok;

    odd_reads_even_rt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (odd_src_used[i] &&
          (odd_src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == even_rt_addr)) begin
        odd_reads_even_rt = 1'b1;
      end
    end
    // Same-cycle dependency on the even result is not visible in the scoreboard
    // yet, so odd is held back and picks it up from the counter next cycle.
    intra_block  = even_go && even_wr_en &&
                   (odd_reads_even_rt || (odd_wr_en && (odd_rt_addr == even_rt_addr)));
    odd_order_ok = even_done || even_go || !even_valid;

    odd_go = !reset && !flush && odd_valid && odd_srcs_ok && odd_waw_ok &&
             odd_order_ok && !intra_block;

    pair_rdy = !reset && !flush && (even_done || even_go || !even_valid) &&
               (odd_go || !odd_valid);
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_PAIR;
    end else begin
      case (state_q)
        ST_PAIR:     if (even_go && odd_valid && !odd_go) state_d = ST_ODD_ONLY;
        ST_ODD_ONLY: if (odd_go) state_d = ST_PAIR;
        default:     state_d = ST_PAIR;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((even_valid || odd_valid) && !pair_rdy && !flush && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PAIR;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign issue_even  = even_go;
  assign issue_odd   = odd_go;
  assign pair_ready  = pair_rdy;
  assign stall_count = stall_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_issue_hazard_scheduler.sv
module tb_issue_hazard_scheduler;
  import spu_pkg::*;

  localparam int W  = 7;
  localparam int XW = 36;

  logic           clk;
  logic           reset;
  logic           even_valid, odd_valid;
  logic [3*W-1:0] even_src_addr, odd_src_addr;
  logic [2:0]     even_src_used, odd_src_used;
  logic           even_wr_en, odd_wr_en;
  logic [W-1:0]   even_rt_addr, odd_rt_addr;
  logic [2:0]     even_unit, odd_unit;
  logic           flush;
  logic           issue_even, issue_odd, pair_ready;
  logic [31:0]    stall_count;
  logic           dbg_state;

  issue_hazard_scheduler #(
    .NUM_REGS(128), .REG_ADDR_WIDTH(W), .CNT_WIDTH(3), .STALL_CNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset),
    .even_valid(even_valid), .even_src_addr(even_src_addr), .even_src_used(even_src_used),
    .even_wr_en(even_wr_en), .even_rt_addr(even_rt_addr), .even_unit(even_unit),
    .odd_valid(odd_valid), .odd_src_addr(odd_src_addr), .odd_src_used(odd_src_used),
    .odd_wr_en(odd_wr_en), .odd_rt_addr(odd_rt_addr), .odd_unit(odd_unit),
    .flush(flush), .issue_even(issue_even), .issue_odd(issue_odd),
    .pair_ready(pair_ready), .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry layout: {issue_even, issue_odd, pair_ready, state, stall_count[31:0]}
  logic [XW-1:0] exp_q[$];
  logic [XW-1:0] mask_q[$];
  string         tag_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  localparam logic [XW-1:0] MASK_ALL = {XW{1'b1}};
  localparam logic [XW-1:0] MASK_OUT = {3'b111, 33'b0};

  logic [XW-1:0] act;
  assign act = {issue_even, issue_odd, pair_ready, dbg_state, stall_count};

  // Monitor: mid-cycle, compares the DUT against the oldest expected entry.
  always @(negedge clk) begin
    logic [XW-1:0] e, m;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      t = tag_q.pop_front();
      n_tests++;
      if ((act & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL %s: got ie/io/pr=%b%b%b st=%0d stall=%0d, expected ie/io/pr=%b%b%b st=%0d stall=%0d%s",
                 t, act[35], act[34], act[33], act[32], act[31:0],
                 e[35], e[34], e[33], e[32], e[31:0], (m == MASK_ALL) ? "" : " (outputs only)");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic ie, input logic io, input logic pr,
                      input logic st, input int cnt, input logic full);
    exp_q.push_back({ie, io, pr, st, 32'(cnt)});
    mask_q.push_back(full ? MASK_ALL : MASK_OUT);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic set_even(input logic v, input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic [W-1:0] rc, input logic [2:0] used, input logic wr,
                          input logic [W-1:0] rt, input logic [2:0] unit);
    even_valid = v; even_src_addr = {ra, rb, rc}; even_src_used = used;
    even_wr_en = wr; even_rt_addr = rt; even_unit = unit;
  endtask

  task automatic set_odd(input logic v, input logic [W-1:0] ra, input logic [W-1:0] rb,
                         input logic [W-1:0] rc, input logic [2:0] used, input logic wr,
                         input logic [W-1:0] rt, input logic [2:0] unit);
    odd_valid = v; odd_src_addr = {ra, rb, rc}; odd_src_used = used;
    odd_wr_en = wr; odd_rt_addr = rt; odd_unit = unit;
  endtask

  task automatic clear_slots();
    set_even(1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, 7'd0, UNIT_FX1);
    set_odd (1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, 7'd0, UNIT_FX1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("reset_outputs", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_slots();
    @(posedge clk);
    #1;

    // Reset: outputs held low even with a ready pair; state/stall cleared.
    set_even(1'b1, 7'd1, 7'd2, 7'd0, 3'b110, 1'b1, 7'd3, UNIT_FX1);
    step("rst_hold", 0, 0, 0, 0, 0, 0);
    step("rst_regs", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;

    // Independent pair: both issue together.
    set_even(1'b1, 7'd1, 7'd2, 7'd0, 3'b110, 1'b1, 7'd3, UNIT_FX1);
    set_odd (1'b1, 7'd6, 7'd0, 7'd0, 3'b100, 1'b1, 7'd4, UNIT_PERM);
    step("indep_pair", 1, 1, 1, 0, 0, 1);
    clear_slots();
    step("indep_idle", 0, 0, 1, 0, 0, 1);

    // RAW across pairs on r5.
    do_reset();
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd5, UNIT_FX1);
    step("raw_prod", 1, 0, 1, 0, 0, 1);
    set_even(1'b1, 7'd5, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, UNIT_FX1);
    step("raw_stall", 0, 0, 0, 0, 0, 1);
    step("raw_issue", 1, 0, 1, 0, 1, 1);
    clear_slots();
    step("raw_idle", 0, 0, 1, 0, 1, 1);

    // Intra-pair RAW: even fx2 writes r10, odd reads r10.
    do_reset();
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd10, UNIT_FX2);
    set_odd (1'b1, 7'd10, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, UNIT_FX1);
    step("intra_c0", 1, 0, 0, 0, 0, 1);
    step("intra_c1", 0, 0, 0, 1, 1, 1);
    step("intra_c2", 0, 0, 0, 1, 2, 1);
    step("intra_c3", 0, 1, 1, 1, 3, 1);
    clear_slots();
    step("intra_idle", 0, 0, 1, 0, 3, 1);

    // Odd reading rc of even's rt is also blocked intra-pair.
    do_reset();
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd11, UNIT_FX1);
    set_odd (1'b1, 7'd1, 7'd2, 7'd11, 3'b001, 1'b0, 7'd0, UNIT_FX1);
    step("intra_rc_c0", 1, 0, 0, 0, 0, 1);
    step("intra_rc_c1", 0, 0, 0, 1, 1, 1);
    step("intra_rc_c2", 0, 1, 1, 1, 2, 1);
    clear_slots();

    // Intra-pair WAW on r12.
    do_reset();
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd12, UNIT_FX1);
    set_odd (1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd12, UNIT_FX1);
    step("iwaw_c0", 1, 0, 0, 0, 0, 1);
    step("iwaw_c1", 0, 0, 0, 1, 1, 1);
    step("iwaw_c2", 0, 1, 1, 1, 2, 1);
    clear_slots();
    step("iwaw_idle", 0, 0, 1, 0, 2, 1);

    // WAW across pairs: odd ls writes r7, then even fx1 writes r7.
    do_reset();
    set_odd(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd7, UNIT_LS);
    step("waw_prod", 0, 1, 1, 0, 0, 1);
    set_odd(1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, 7'd0, UNIT_FX1);
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd7, UNIT_FX1);
    for (int i = 0; i < 5; i++) step($sformatf("waw_hold%0d", i + 1), 0, 0, 0, 0, i, 1);
    step("waw_issue", 1, 0, 1, 0, 5, 1);
    clear_slots();
    step("waw_idle", 0, 0, 1, 0, 5, 1);

    // Flush while ODD_ONLY with odd blocked on r10.
    do_reset();
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd10, UNIT_FX2);
    set_odd (1'b1, 7'd10, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, UNIT_FX1);
    step("flush_c0", 1, 0, 0, 0, 0, 1);
    flush = 1'b1;
    step("flush_c1", 0, 0, 0, 1, 1, 1);
    flush = 1'b0;
    set_odd (1'b0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, 7'd0, UNIT_FX1);
    set_even(1'b1, 7'd10, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, UNIT_FX1);
    step("flush_c2", 0, 0, 0, 0, 1, 1);
    step("flush_c3", 1, 0, 1, 0, 2, 1);
    clear_slots();

    // Reset mid-operation while r20 is busy.
    do_reset();
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd20, UNIT_SP_INT);
    step("rmid_prod", 1, 0, 1, 0, 0, 1);
    set_even(1'b1, 7'd20, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, UNIT_FX1);
    reset = 1'b1;
    flush = 1'b1;
    step("rmid_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    flush = 1'b0;
    step("rmid_after", 1, 0, 1, 0, 0, 1);
    clear_slots();

    // In-order: odd independent but even blocked on r0 (an ordinary register).
    do_reset();
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd0, UNIT_FX1);
    step("order_prod", 1, 0, 1, 0, 0, 1);
    set_even(1'b1, 7'd0, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, UNIT_FX1);
    set_odd (1'b1, 7'd1, 7'd0, 7'd0, 3'b100, 1'b1, 7'd2, UNIT_FX1);
    step("order_hold", 0, 0, 0, 0, 0, 1);
    step("order_both", 1, 1, 1, 0, 1, 1);
    clear_slots();
    step("order_idle", 0, 0, 1, 0, 1, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
